// File: rtl/tx_ctrl_pkg.sv
// Shared types and default widths for the TX sweep sequencer.
package tx_ctrl_pkg;

   localparam int DEF_PW_I = 19;   // phase / frequency word width
   localparam int DEF_IW   = 16;   // baseband sample width
   localparam int DEF_DW   = 16;   // dwell counter width

   // Largest amplitude that keeps the scaled output inside the signed sample range.
   localparam logic [DEF_IW-1:0] AMP_MAX = DEF_IW'((1 << (DEF_IW - 1)) - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_SWEEP     = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } tx_state_t;

endpackage

// File: rtl/tx_amp_scaler.sv
// One baseband channel scaled by an unsigned amplitude: (bb * amp) >>> (IW-1).
// Two register stages: product, then shifted/truncated output.
module tx_amp_scaler
   import tx_ctrl_pkg::*;
#(
   parameter int IW = DEF_IW
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic signed [IW-1:0] i_bb,
   input  logic [IW-2:0]        i_amp,
   output logic signed [IW-1:0] o_tx
);

   // Operands widened to the exact product width so the multiply never truncates.
   logic signed [2*IW-2:0] w_bb_ext;
   logic signed [2*IW-2:0] w_amp_ext;
   logic signed [2*IW-2:0] w_prod;
   logic signed [2*IW-2:0] r_prod;

   assign w_bb_ext  = {{(IW-1){i_bb[IW-1]}}, i_bb};
   assign w_amp_ext = {{IW{1'b0}}, i_amp};
   assign w_prod    = w_bb_ext * w_amp_ext;

   // Product stage, then arithmetic shift (floor) into the output register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
         o_tx   <= '0;
      end else begin
         r_prod <= w_prod;
         o_tx   <= IW'(r_prod >>> (IW - 1));
      end
   end

endmodule

// File: rtl/tx_sweep_ctrl.sv
// TX channel sequencer: amplitude ramp-up, stepped frequency sweep with dwell,
// amplitude ramp-down. Configuration is shadowed at run start.
module tx_sweep_ctrl
   import tx_ctrl_pkg::*;
#(
   parameter int PW_I = DEF_PW_I,
   parameter int IW   = DEF_IW,
   parameter int DW   = DEF_DW
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic                 ce_up,
   input  logic                 start,
   input  logic                 abort,
   input  logic [PW_I-1:0]      cfg_f_start,
   input  logic [PW_I-1:0]      cfg_f_stop,
   input  logic [PW_I-1:0]      cfg_f_step,
   input  logic [DW-1:0]        cfg_dwell,
   input  logic [IW-1:0]        cfg_amp,
   input  logic [IW-1:0]        cfg_amp_step,
   input  logic                 cfg_loop,
   input  logic signed [IW-1:0] bb_x,
   input  logic signed [IW-1:0] bb_y,
   output logic signed [IW-1:0] tx_x,
   output logic signed [IW-1:0] tx_y,
   output logic [PW_I-1:0]      phase_out,
   output logic [PW_I-1:0]      ftw_out,
   output logic                 busy,
   output logic                 done
);

   localparam logic [IW-2:0] L_AMP_MAX = '1;

   tx_state_t        r_state;
   logic [PW_I-1:0]  r_freq;
   logic [PW_I-1:0]  r_phase;
   logic [IW-2:0]    r_amp;       // never exceeds the clamp, so IW-1 bits suffice
   logic [DW-1:0]    r_dwell;
   logic             r_done;

   // Shadow copies of the configuration, frozen for the whole run.
   logic [PW_I-1:0]  r_f_start;
   logic [PW_I-1:0]  r_f_stop;
   logic [PW_I-1:0]  r_f_step;
   logic [DW-1:0]    r_dwell_max;
   logic [IW-2:0]    r_amp_tgt;
   logic [IW-1:0]    r_amp_step;
   logic             r_loop;

   logic             w_start_ok;
   logic [PW_I:0]    w_f_next;     // one extra bit so the step comparison sees overflow
   logic [IW:0]      w_up_sum;
   logic             w_up_reach;
   logic             w_down_zero;

   assign w_start_ok  = (r_state == ST_IDLE) && start;
   assign w_f_next    = {1'b0, r_freq} + {1'b0, r_f_step};
   assign w_up_sum    = {2'b00, r_amp} + {1'b0, r_amp_step};
   assign w_up_reach  = (r_amp_step == '0) || (w_up_sum >= {2'b00, r_amp_tgt});
   assign w_down_zero = (r_amp_step == '0) || (r_amp_step >= {1'b0, r_amp});

   // Capture configuration when a run is accepted; clamp amplitude to the safe maximum.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f_start   <= '0;
         r_f_stop    <= '0;
         r_f_step    <= '0;
         r_dwell_max <= '0;
         r_amp_tgt   <= '0;
         r_amp_step  <= '0;
         r_loop      <= 1'b0;
      end else if (w_start_ok) begin
         r_f_start   <= cfg_f_start;
         r_f_stop    <= cfg_f_stop;
         r_f_step    <= cfg_f_step;
         r_dwell_max <= cfg_dwell;
         r_amp_tgt   <= cfg_amp[IW-1] ? L_AMP_MAX : cfg_amp[IW-2:0];
         r_amp_step  <= cfg_amp_step;
         r_loop      <= cfg_loop;
      end
   end

   // Phase accumulator: cleared at run start, free-running (wrapping) while active.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
      end else if (w_start_ok) begin
         r_phase <= '0;
      end else if (r_state != ST_IDLE) begin
         r_phase <= r_phase + r_freq;
      end
   end

   // Run sequencing: amplitude ramps, dwell counting and frequency stepping.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_freq  <= '0;
         r_amp   <= '0;
         r_dwell <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RAMP_UP;
                  r_freq  <= cfg_f_start;
                  r_amp   <= '0;
                  r_dwell <= '0;
               end
            end
            ST_RAMP_UP: begin
               if (abort) begin
                  r_state <= ST_RAMP_DOWN;
               end else if (ce_up) begin
                  if (w_up_reach) begin
                     r_amp   <= r_amp_tgt;
                     r_state <= ST_SWEEP;
                  end else begin
                     r_amp <= w_up_sum[IW-2:0];
                  end
               end
            end
            ST_SWEEP: begin
               if (abort) begin
                  r_state <= ST_RAMP_DOWN;
               end else if (ce_up) begin
                  if (r_dwell == r_dwell_max) begin
                     r_dwell <= '0;
                     if (w_f_next <= {1'b0, r_f_stop}) begin
                        r_freq <= w_f_next[PW_I-1:0];
                     end else if (r_loop) begin
                        r_freq <= r_f_start;
                     end else begin
                        r_state <= ST_RAMP_DOWN;
                     end
                  end else begin
                     r_dwell <= r_dwell + 1'b1;
                  end
               end
            end
            ST_RAMP_DOWN: begin
               if (ce_up) begin
                  if (w_down_zero) begin
                     r_amp   <= '0;
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_amp <= r_amp - r_amp_step[IW-2:0];
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   logic signed [IW-1:0] w_bb [2];
   logic signed [IW-1:0] w_tx [2];

   assign w_bb[0] = bb_x;
   assign w_bb[1] = bb_y;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_scale
         tx_amp_scaler #(.IW(IW)) u_scaler (
            .sys_clk (sys_clk),
            .rst_n   (rst_n),
            .i_bb    (w_bb[gi]),
            .i_amp   (r_amp),
            .o_tx    (w_tx[gi])
         );
      end
   endgenerate

   assign tx_x      = w_tx[0];
   assign tx_y      = w_tx[1];
   assign phase_out = r_phase;
   assign ftw_out   = r_freq;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;

endmodule

// File: tb/tb_tx_sweep_ctrl.sv
// Bench for tx_sweep_ctrl: per-cycle comparison against a reference model,
// a scaling vector table, and hand-written multi-cycle sequences.
module tb_tx_sweep_ctrl;

   localparam longint PMOD = 524288;   // 2^19
   localparam int M_IDLE = 0, M_UP = 1, M_SWEEP = 2, M_DOWN = 3;

   logic              sys_clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ce_up = 1'b0, start = 1'b0, abort = 1'b0, cfg_loop = 1'b0;
   logic [18:0]       cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0;
   logic [15:0]       cfg_dwell = '0, cfg_amp = '0, cfg_amp_step = '0;
   logic signed [15:0] bb_x = '0, bb_y = '0;
   logic signed [15:0] tx_x, tx_y;
   logic [18:0]       phase_out, ftw_out;
   logic              busy, done;

   tx_sweep_ctrl dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .ce_up(ce_up), .start(start), .abort(abort),
      .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
      .cfg_dwell(cfg_dwell), .cfg_amp(cfg_amp), .cfg_amp_step(cfg_amp_step),
      .cfg_loop(cfg_loop), .bb_x(bb_x), .bb_y(bb_y), .tx_x(tx_x), .tx_y(tx_y),
      .phase_out(phase_out), .ftw_out(ftw_out), .busy(busy), .done(done)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int     m_mode;
   longint m_phase, m_freq, m_amp, m_dwell;
   bit     m_done;
   longint s_fs, s_fstop, s_fstep, s_dwell, s_tgt, s_astep;
   bit     s_loop;
   longint qx[$], qy[$];
   longint exp_x, exp_y;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // Floor of (bb*amp)/2^15, done with plain integer division.
   function automatic longint scale(input longint bb, input longint amp);
      longint p, r;
      p = bb * amp;
      r = p % 32768;
      if (r < 0) r += 32768;
      return (p - r) / 32768;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_phase = 0; m_freq = 0; m_amp = 0; m_dwell = 0; m_done = 0;
      qx.delete(); qy.delete();
      qx.push_back(0); qy.push_back(0);
      exp_x = 0; exp_y = 0;
   endtask

   task automatic model_clock();
      longint nxt, a;
      qx.push_back(scale(bb_x, m_amp));
      qy.push_back(scale(bb_y, m_amp));
      exp_x = qx.pop_front();
      exp_y = qy.pop_front();
      m_done = 0;
      if (m_mode != M_IDLE) m_phase = (m_phase + m_freq) % PMOD;
      case (m_mode)
         M_IDLE: if (start) begin
            s_fs = cfg_f_start; s_fstop = cfg_f_stop; s_fstep = cfg_f_step;
            s_dwell = cfg_dwell; s_astep = cfg_amp_step; s_loop = cfg_loop;
            s_tgt = (cfg_amp > 32767) ? 32767 : cfg_amp;
            m_freq = s_fs; m_phase = 0; m_amp = 0; m_dwell = 0; m_mode = M_UP;
         end
         M_UP: if (abort) m_mode = M_DOWN;
         else if (ce_up) begin
            if (s_astep == 0) a = s_tgt;
            else a = (m_amp + s_astep < s_tgt) ? m_amp + s_astep : s_tgt;
            m_amp = a;
            if (a == s_tgt) m_mode = M_SWEEP;
         end
         M_SWEEP: if (abort) m_mode = M_DOWN;
         else if (ce_up) begin
            if (m_dwell == s_dwell) begin
               m_dwell = 0;
               nxt = m_freq + s_fstep;
               if (nxt <= s_fstop) m_freq = nxt;
               else if (s_loop) m_freq = s_fs;
               else m_mode = M_DOWN;
            end else m_dwell++;
         end
         default: if (ce_up) begin
            a = (s_astep == 0 || m_amp <= s_astep) ? 0 : m_amp - s_astep;
            m_amp = a;
            if (a == 0) begin m_mode = M_IDLE; m_done = 1; end
         end
      endcase
   endtask

   task automatic tick();
      @(posedge sys_clk);
      model_clock();
      #1;
      chk("phase_out", phase_out, m_phase);
      chk("ftw_out", ftw_out, m_freq);
      chk("tx_x", tx_x, exp_x);
      chk("tx_y", tx_y, exp_y);
      chk("busy", busy, (m_mode != M_IDLE) ? 1 : 0);
      chk("done", done, m_done);
   endtask

   task automatic set_cfg(input longint fs, input longint fstop, input longint fstep,
                          input longint dw, input longint amp, input longint astep, input bit lp);
      cfg_f_start = 19'(fs); cfg_f_stop = 19'(fstop); cfg_f_step = 19'(fstep);
      cfg_dwell = 16'(dw); cfg_amp = 16'(amp); cfg_amp_step = 16'(astep); cfg_loop = lp;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      int n = 0;
      bit seen = 0;
      while (!seen && n < limit) begin
         ce_up = 1'b1; tick(); n++;
         if (done) seen = 1;
      end
      ce_up = 1'b0;
      chk(name, seen, 1);
   endtask

   task automatic end_run(input string name);
      abort = 1'b1; tick(); abort = 1'b0;
      wait_done(40000, name);
   endtask

   task automatic run_until_ftw(input longint val, input int limit, input string name);
      int n = 0;
      while (ftw_out != val && n < limit) begin
         ce_up = 1'b1; tick(); n++;
      end
      ce_up = 1'b0;
      chk(name, ftw_out, val);
   endtask

   typedef struct {
      logic [15:0]        amp;
      logic signed [15:0] bx, by, ex, ey;
   } vec_t;
   vec_t tbl[8];

   initial begin
      longint ramp, exp_f;
      int n, sel, cur_amp;

      tbl[0] = '{16'd32767, -16'sd32768, 16'sd32767, -16'sd32767, 16'sd32766};
      tbl[1] = '{16'd32767, 16'sd1000, -16'sd1, 16'sd999, -16'sd1};
      tbl[2] = '{16'd32767, 16'sd0, -16'sd1000, 16'sd0, -16'sd1000};
      tbl[3] = '{16'd16384, 16'sd1000, -16'sd1000, 16'sd500, -16'sd500};
      tbl[4] = '{16'd16384, -16'sd1, 16'sd32767, -16'sd1, 16'sd16383};
      tbl[5] = '{16'd16384, -16'sd32768, 16'sd1, -16'sd16384, 16'sd0};
      tbl[6] = '{16'hFFFF, -16'sd32768, 16'sd2, -16'sd32767, 16'sd1};
      tbl[7] = '{16'h8000, 16'sd16384, -16'sd16384, 16'sd16383, -16'sd16384};

      // Reset state
      model_reset();
      #2;
      chk("rst_phase", phase_out, 0);
      chk("rst_ftw", ftw_out, 0);
      chk("rst_tx_x", tx_x, 0);
      chk("rst_tx_y", tx_y, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      #10 rst_n = 1'b1;
      tick();

      // Basic sweep, ce_up every 4th cycle; bb_x = -32768 makes tx_x = -amp.
      set_cfg(1000, 1300, 100, 3, 16384, 4096, 0);
      bb_x = -16'sd32768; bb_y = 16'sd12345;
      pulse_start();
      for (int k = 1; k <= 24; k++) begin
         ce_up = 1'b1; tick(); ce_up = 1'b0;
         exp_f = (k < 8) ? 1000 : (k < 12) ? 1100 : (k < 16) ? 1200 : 1300;
         chk("basic_ftw", ftw_out, exp_f);
         chk("basic_done", done, (k == 24) ? 1 : 0);
         tick(); tick();
         ramp = (k <= 4) ? 4096 * k : (k <= 20) ? 16384 : 16384 - 4096 * (k - 20);
         chk("basic_amp", tx_x, -ramp);
         tick();
      end
      chk("basic_idle", busy, 0);

      // Abort in SWEEP at 1100, coinciding with a strobe; a start while busy is ignored.
      pulse_start();
      run_until_ftw(1100, 200, "abort_reach");
      abort = 1'b1; ce_up = 1'b1; tick(); abort = 1'b0; ce_up = 1'b0;
      chk("abort_freeze", ftw_out, 1100);
      cfg_f_start = 19'd5000;
      pulse_start();
      chk("abort_busy", busy, 1);
      n = 0;
      while (!done && n < 20) begin ce_up = 1'b1; tick(); n++; end
      ce_up = 1'b0;
      chk("abort_down_strobes", n, 4);
      chk("abort_ftw_hold", ftw_out, 1100);
      tick(); tick();
      chk("abort_no_restart", busy, 0);

      // Loop mode: 1300 wraps back to 1000 without ramping down.
      set_cfg(1000, 1300, 100, 3, 16384, 0, 1);
      pulse_start();
      run_until_ftw(1300, 200, "loop_reach");
      n = 0;
      while (ftw_out == 19'd1300 && n < 50) begin ce_up = 1'b1; tick(); n++; end
      ce_up = 1'b0;
      chk("loop_wrap", ftw_out, 1000);
      chk("loop_busy", busy, 1);
      end_run("loop_done");

      // f_step = 0 holds f_start; amp_step = 0 jumps to the clamped target.
      set_cfg(1000, 1300, 0, 3, 16'hFFFF, 0, 0);
      pulse_start();
      ce_up = 1'b1; tick(); ce_up = 1'b0;
      tick(); tick();
      chk("jump_clamp_amp", tx_x, -32767);
      for (int k = 0; k < 60; k++) begin ce_up = 1'b1; tick(); end
      ce_up = 1'b0;
      chk("step0_hold", ftw_out, 1000);
      chk("step0_busy", busy, 1);
      end_run("step0_done");

      // Phase wrap at freq = 2^18.
      set_cfg(262144, 262144, 0, 0, 100, 100, 0);
      pulse_start();
      chk("wrap_c1", phase_out, 0);
      tick(); chk("wrap_c2", phase_out, 262144);
      tick(); chk("wrap_c3", phase_out, 0);
      tick(); chk("wrap_c4", phase_out, 262144);
      end_run("wrap_done");

      // Asynchronous reset in the middle of a sweep.
      set_cfg(1000, 1300, 100, 3, 16384, 4096, 0);
      bb_x = 16'sd7000;
      pulse_start();
      run_until_ftw(1100, 200, "arst_reach");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_phase", phase_out, 0);
      chk("arst_ftw", ftw_out, 0);
      chk("arst_tx_x", tx_x, 0);
      chk("arst_tx_y", tx_y, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      @(posedge sys_clk); #1;
      chk("arst_hold_done", done, 0);
      #2 rst_n = 1'b1;
      tick();
      pulse_start();
      chk("arst_restart_busy", busy, 1);
      wait_done(200, "arst_restart_done");

      // Scaling table.
      cur_amp = -1;
      for (int i = 0; i < 8; i++) begin
         if (int'(tbl[i].amp) != cur_amp) begin
            if (busy) end_run("tbl_end");
            set_cfg(1000, 1000, 0, 0, tbl[i].amp, 0, 0);
            pulse_start();
            ce_up = 1'b1; tick(); ce_up = 1'b0;
            cur_amp = int'(tbl[i].amp);
         end
         bb_x = tbl[i].bx; bb_y = tbl[i].by;
         tick(); tick();
         chk("tbl_x", tx_x, tbl[i].ex);
         chk("tbl_y", tx_y, tbl[i].ey);
      end
      end_run("tbl_done");

      // Randomized traffic, including configuration changes during runs.
      for (int c = 0; c < 20000; c++) begin
         ce_up = ($urandom_range(0, 1) == 1);
         start = ($urandom_range(0, 29) == 0);
         abort = ($urandom_range(0, 149) == 0);
         bb_x = 16'($urandom);
         bb_y = 16'($urandom);
         cfg_loop = ($urandom_range(0, 1) == 1);
         cfg_dwell = 16'($urandom_range(0, 3));
         cfg_f_start = 19'($urandom);
         cfg_f_step = ($urandom_range(0, 3) == 0) ? 19'd0 : 19'($urandom_range(1, 70000));
         cfg_f_stop = 19'(longint'(cfg_f_start) + longint'(cfg_f_step) * $urandom_range(0, 4)
                          + $urandom_range(0, 3));
         cfg_amp = 16'($urandom);
         sel = $urandom_range(0, 3);
         cfg_amp_step = (sel == 0) ? 16'd0 : (sel == 1) ? 16'($urandom) : (cfg_amp >> sel);
         tick();
      end
      start = 1'b0; abort = 1'b0; ce_up = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_sweep_ctrl.md
# tx_sweep_ctrl

Sequencer for the transmit channel. It generates the 19-bit upconversion phase word and scales the I/Q baseband before the TX upsamplers. A run has three parts: an amplitude ramp-up, a stepped frequency sweep with a programmable dwell per step, and an amplitude ramp-down. Configuration is captured from CSRs when the run starts, so the TX output never glitches from a mid-run register write.

## Interface
- `PW_I`, 19, phase / frequency-word width; matches the TX channel phase input.
- `IW`, 16, baseband sample width.
- `DW`, 16, dwell counter width.
- `sys_clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ce_up`  in  1  upsampler output strobe from the TX channel; sets the dwell and ramp tick rate.
- `start`  in  1  one-cycle pulse; begins a run.
- `abort`  in  1  one-cycle pulse; forces ramp-down.
- `cfg_f_start`, `cfg_f_stop`, `cfg_f_step`  in  PW_I each  unsigned frequency words.
- `cfg_dwell`  in  DW  `ce_up` strobes per step, minus 1.
- `cfg_amp`  in  IW  target amplitude, unsigned.
- `cfg_amp_step`  in  IW  ramp increment per `ce_up`.
- `cfg_loop`  in  1  1 = restart the sweep at `f_start` instead of ramping down.
- `bb_x`, `bb_y`  in  IW signed  baseband in.
- `tx_x`, `tx_y`  out  IW signed  scaled baseband out, to the upsamplers.
- `phase_out`  out  PW_I  phase word to the TX channel.
- `ftw_out`  out  PW_I  current frequency word.
- `busy`  out  1  high while a run is active.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- **States:** IDLE, RAMP_UP, SWEEP, RAMP_DOWN.
- **Reset:** state IDLE. All outputs are 0: `phase_out`, `ftw_out`, `tx_x`, `tx_y`, `busy`, `done`. Internal amplitude is 0.
- **IDLE + start:**
  - Latch every `cfg_*` input into shadow registers.
  - `cfg_amp` ≥ 2^(IW-1) is clamped to 2^(IW-1)-1.
  - Set freq = `f_start`, phase = 0, amp = 0, dwell count = 0, then go to RAMP_UP.
  - An `abort` in the same cycle is ignored.
  - `start` while busy is ignored.
- **Phase accumulator:** while not IDLE, phase <= phase + freq every `sys_clk`, modulo 2^PW_I (wraps silently). In IDLE, phase holds its last value.
- **RAMP_UP:**
  - On each `ce_up`, amp <= min(amp + step, amp_tgt).
  - When amp reaches amp_tgt, go to SWEEP.
  - If `amp_step` = 0, amp is loaded with amp_tgt on the first `ce_up`.
- **SWEEP:**
  - Dwell counter counts `ce_up` strobes. At count = dwell it clears, and the step is evaluated in PW_I+1 bits as next = freq + `f_step`.
  - next ≤ `f_stop`: freq <= next.
  - next > `f_stop` and `cfg_loop` = 1: freq <= `f_start`.
  - next > `f_stop` and `cfg_loop` = 0: go to RAMP_DOWN; freq is held.
  - `f_step` = 0: sweep holds at `f_start` until abort.
  - `f_start` > `f_stop`: a single dwell at `f_start`, then the cfg_loop rule applies.
- **RAMP_DOWN:**
  - On each `ce_up`, amp <= max(amp - step, 0). A step of 0 zeroes amp immediately.
  - When amp = 0, go to IDLE, pulse `done`, and drop `busy`.
- **abort:** in RAMP_UP or SWEEP, go to RAMP_DOWN from the current amp, with freq frozen. Ignored in RAMP_DOWN and IDLE.
- **Scaling:**
  - tx = (bb × amp) >>> (IW-1), computed as an IW × (IW-1) signed × unsigned product, truncated toward −∞.
  - amp ≤ 2^(IW-1)-1, so the result never overflows.
  - `tx_x`/`tx_y` are 0 whenever amp = 0.
- **Outputs:** `ftw_out` = freq; `phase_out` = phase register.
- **Reset mid-run:** asynchronous return to reset values. No done pulse.

## Timing
- `start` at cycle 0: `busy` = 1 and state = RAMP_UP from cycle 1.
- `phase_out` first advances at cycle 2.
- `bb` → `tx` latency: 2 cycles (product register, then output register).
- amp and freq updates take effect the cycle after the qualifying `ce_up`.
- `done` is high for exactly 1 cycle, coinciding with the first cycle of `busy` = 0.
- `ce_up` and `abort` in the same cycle in SWEEP: abort wins, and no frequency step is taken.
- Fresh `start` accepted the cycle after `done`.

## Structure
- **Package `tx_ctrl_pkg`:**
  - state enum (2 bits): IDLE=0, RAMP_UP=1, SWEEP=2, RAMP_DOWN=3.
  - default widths `PW_I`, `IW`, `DW`.
  - amplitude clamp constant AMP_MAX = 2^(IW-1)-1.
- **Sub-module `tx_amp_scaler`:** one registered signed × unsigned multiply-shift, instantiated twice (x and y).
- **Top level:** the FSM, shadow registers, accumulator and counters.

## Test plan
- **Basic sweep:** f_start=1000, f_stop=1300, f_step=100, dwell=3, amp=16384, amp_step=4096, loop=0; `ce_up` every 4th cycle.
  - RAMP_UP takes 4 strobes.
  - `ftw_out` sequence 1000, 1100, 1200, 1300, each held 4 strobes.
  - RAMP_DOWN takes 4 strobes, then one `done` pulse.
- **Scaling:** amp=32767 with bb_x=-32768 → tx_x = -32767; with bb_x=32767 → tx_x = 32766. amp=16384 with bb_x=1000 → tx_x = 500. Result appears 2 cycles after input.
- **Abort in SWEEP at `ftw_out`=1100:** freq freezes at 1100, ramp-down starts from 16384, `done` is pulsed, and the `start` issued while busy is ignored.
- **Edge cases:**
  - loop=1: freq sequence 1300 → 1000 after the final dwell; no ramp-down.
  - f_step=0: holds 1000 until abort.
  - amp_step=0: amp jumps straight to target.
  - cfg_amp=0xFFFF: clamped to 32767.
- **Phase wrap:** freq = 2^18 for 4 cycles → `phase_out` = 0, 2^18, 0, 2^18 (wraps modulo 2^19).
- **Async reset mid-SWEEP:** all outputs go to 0 immediately, no `done` pulse, and a new `start` after release runs normally.
